// File: rtl/fp_pkg.sv
// Shared constants and bit-pattern builders for the pipelined FP multiplier.
// Builders return 64-bit patterns; callers cast down to their word width.
package fp_pkg;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_INV  = 2'b11;

  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic logic [63:0] zero_bits(
    input logic s,
    input int   ew,
    input int   fw
  );
    return 64'(s) << (ew + fw);
  endfunction

  function automatic logic [63:0] inf_bits(
    input logic s,
    input int   ew,
    input int   fw
  );
    logic [63:0] r;
    r = (64'(s) << (ew + fw)) | (((64'd1 << ew) - 64'd1) << fw);
    return r;
  endfunction

  function automatic logic [63:0] qnan_bits(
    input int ew,
    input int fw
  );
    logic [63:0] r;
    r = (((64'd1 << ew) - 64'd1) << fw) | (64'd1 << (fw - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Normalise a raw mantissa product, round it, and flag over/underflow.
// Purely combinational; the caller owns special-value handling.
module fp_mul_round
  import fp_pkg::*;
#(
  parameter int EW = 8,
  parameter int FW = 7
) (
  input  logic                sign_i,
  input  logic signed [EW+1:0] exp_i,
  input  logic [2*FW+1:0]     prod_i,
  input  logic                trunc_i,
  output logic [EW+FW:0]      res_o,
  output logic                ovf_o,
  output logic                unf_o
);

  localparam logic signed [EW+1:0] EMAX = (EW + 2)'((1 << EW) - 1);

  logic                msb;
  logic [2*FW+1:0]     norm;
  logic [FW-1:0]       frac;
  logic                guard;
  logic                sticky;
  logic                up;
  logic [FW:0]         fsum;
  logic signed [EW+1:0] e_n;
  logic                unused_bits;

  assign msb    = prod_i[2*FW+1];
  assign norm   = msb ? prod_i : {prod_i[2*FW:0], 1'b0};
  assign frac   = norm[2*FW:FW+1];
  assign guard  = norm[FW];
  assign sticky = |norm[FW-1:0];
  assign up     = !trunc_i && guard && (sticky || frac[0]);
  assign fsum   = {1'b0, frac} + (FW + 1)'(up);

  // a rounding carry leaves fsum[FW-1:0] at zero, so only the exponent moves
  assign e_n = exp_i
             + $signed({{(EW+1){1'b0}}, msb})
             + $signed({{(EW+1){1'b0}}, fsum[FW]});

  assign ovf_o = (e_n >= EMAX);
  assign unf_o = !ovf_o && (e_n[EW+1] || (e_n == '0));

  always_comb begin
    res_o = {sign_i, e_n[EW-1:0], fsum[FW-1:0]};
    if (ovf_o) begin
      res_o = {sign_i, {EW{1'b1}}, {FW{1'b0}}};
    end else if (unf_o) begin
      res_o = {sign_i, {(EW+FW){1'b0}}};
    end
  end

  assign unused_bits = norm[2*FW+1];

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier with valid/ready handshake.
// Classification before stage 1; product and rounding in later stages.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int EXP_WIDTH   = 8,
  parameter int FRAC_WIDTH  = 7,
  parameter int ERROR_WIDTH = 2,
  parameter int STAGES      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in1,
  input  logic [DATA_WIDTH-1:0]  in2,
  input  logic                   rnd_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out,
  output logic [ERROR_WIDTH-1:0] error
);

  localparam int DW = DATA_WIDTH;
  localparam int EW = EXP_WIDTH;
  localparam int FW = FRAC_WIDTH;
  localparam int PW = 2 * FW + 2;
  localparam int XW = EW + 2;
  localparam int PROD_IDX = (STAGES > 1) ? 1 : 0;
  localparam int RND_IDX  = (STAGES > 2) ? 2 : PROD_IDX;
  localparam logic [XW-1:0] BIAS = XW'(bias(EW));

  typedef struct packed {
    logic                   v;
    logic                   sgn;
    logic                   trunc;
    logic                   spec;
    logic [DW-1:0]          spec_out;
    logic [ERROR_WIDTH-1:0] spec_err;
    logic [XW-1:0]          exp;
    logic [FW:0]            m1;
    logic [FW:0]            m2;
    logic [PW-1:0]          prod;
    logic [DW-1:0]          res;
    logic [ERROR_WIDTH-1:0] err;
  } stage_t;

  logic          s1, s2, sgn;
  logic [EW-1:0] e1, e2;
  logic [FW-1:0] f1, f2;
  logic          z1, z2, inf1, inf2, nan1, nan2;
  logic [DW-1:0] b_inf, b_zero, b_nan;
  logic          adv;
  stage_t        cls;
  stage_t [STAGES-1:0] q_all;
  logic          unused_tail;

  assign {s1, e1, f1} = in1;
  assign {s2, e2, f2} = in2;
  assign sgn  = s1 ^ s2;
  assign z1   = (e1 == '0);
  assign z2   = (e2 == '0);
  assign inf1 = (&e1) && (f1 == '0);
  assign inf2 = (&e2) && (f2 == '0);
  assign nan1 = (&e1) && (|f1);
  assign nan2 = (&e2) && (|f2);

  assign b_inf  = DW'(inf_bits(sgn, EW, FW));
  assign b_zero = DW'(zero_bits(sgn, EW, FW));
  assign b_nan  = DW'(qnan_bits(EW, FW));

  // subnormal inputs count as zero; first matching class wins
  always_comb begin
    cls       = '0;
    cls.v     = in_valid;
    cls.sgn   = sgn;
    cls.trunc = rnd_mode;
    cls.exp   = {2'b00, e1} + {2'b00, e2} - BIAS;
    cls.m1    = {1'b1, f1};
    cls.m2    = {1'b1, f2};
    if (nan1 || nan2 || (inf1 && z2) || (inf2 && z1)) begin
      cls.spec     = 1'b1;
      cls.spec_out = b_nan;
      cls.spec_err = ERROR_WIDTH'(ERR_INV);
    end else if (inf1 || inf2) begin
      cls.spec     = 1'b1;
      cls.spec_out = b_inf;
      cls.spec_err = ERROR_WIDTH'(ERR_NONE);
    end else if (z1 || z2) begin
      cls.spec     = 1'b1;
      cls.spec_out = b_zero;
      cls.spec_err = ERROR_WIDTH'(ERR_NONE);
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_st
    stage_t        src, d, q;
    logic [PW-1:0] mul;
    logic [PW-1:0] rp;
    logic [DW-1:0] rres;
    logic          rovf, runf;

    if (i == 0) begin : g_first
      assign src = cls;
    end else begin : g_next
      assign src = q_all[i-1];
    end

    assign mul = PW'(src.m1) * PW'(src.m2);
    assign rp  = (i == PROD_IDX) ? mul : src.prod;

    if (i == RND_IDX) begin : g_rnd
      fp_mul_round #(
        .EW(EW),
        .FW(FW)
      ) u_round (
        .sign_i (src.sgn),
        .exp_i  ($signed(src.exp)),
        .prod_i (rp),
        .trunc_i(src.trunc),
        .res_o  (rres),
        .ovf_o  (rovf),
        .unf_o  (runf)
      );
    end else begin : g_norm
      assign rres = '0;
      assign rovf = 1'b0;
      assign runf = 1'b0;
    end

    always_comb begin
      d = src;
      if (i == PROD_IDX) d.prod = mul;
      if (i == RND_IDX) begin
        if (src.spec) begin
          d.res = src.spec_out;
          d.err = src.spec_err;
        end else begin
          d.res = rres;
          if (rovf)      d.err = ERROR_WIDTH'(ERR_OVF);
          else if (runf) d.err = ERROR_WIDTH'(ERR_UNF);
          else           d.err = ERROR_WIDTH'(ERR_NONE);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)      q <= '0;
      else if (adv) q <= d;
    end

    assign q_all[i] = q;
  end

  assign out_valid = q_all[STAGES-1].v;
  assign out       = q_all[STAGES-1].res;
  assign error     = q_all[STAGES-1].err;

  assign unused_tail = ^q_all[STAGES-1];

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 16, total operand and result width.
REQ-002 Parameter EXP_WIDTH, default 8, exponent field width.
REQ-003 Parameter FRAC_WIDTH, default 7, stored fraction width; DATA_WIDTH SHALL equal 1+EXP_WIDTH+FRAC_WIDTH.
REQ-004 Parameter ERROR_WIDTH, default 2, error code width.
REQ-005 Parameter STAGES, default 3, legal range 1..6, pipeline depth in register stages.
REQ-006 Port clk  input  1  sole clock, rising edge.
REQ-007 Port rst  input  1  asynchronous, active-high reset.
REQ-008 Port in_valid  input  1  operand pair present.
REQ-009 Port in_ready  output  1  block accepts operands this cycle.
REQ-010 Port in1, in2  input  DATA_WIDTH  operands {sign, exp, frac}.
REQ-011 Port rnd_mode  input  1  0 = round-nearest-even, 1 = truncate; sampled with operands.
REQ-012 Port out_valid  output  1  result present.
REQ-013 Port out_ready  input  1  consumer accepts result.
REQ-014 Port out  output  DATA_WIDTH  product.
REQ-015 Port error  output  ERROR_WIDTH  00 none, 01 overflow, 10 underflow, 11 invalid.

Function
REQ-016 Handshake: transfer on valid&&ready each side; in_ready SHALL equal !out_valid || out_ready (global pipeline advance).
REQ-017 When advance is low, every stage SHALL hold; out, error, out_valid SHALL stay stable until accepted.
REQ-018 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with out_ready held high; throughput one result per cycle.
REQ-019 Results SHALL emerge in input order; no drop, no duplication.
REQ-020 Bubbles (in_valid low on advance) SHALL propagate as invalid stages, not collapse.
REQ-021 Sign = in1 sign XOR in2 sign, for every class including zero, Inf, and overflow/underflow results.
REQ-022 Bias = 2^(EXP_WIDTH-1)-1; exponent arithmetic SHALL use EXP_WIDTH+2 signed bits.
REQ-023 Inputs with exp == 0 (zero or subnormal) SHALL be treated as signed zero.
REQ-024 Mantissa product = {1,frac1}*{1,frac2} (2*FRAC_WIDTH+2 bits); normalise by one bit if MSB set, exponent +1.
REQ-025 RNE: round up if guard && (sticky || lsb); truncate mode: discard guard/sticky.
REQ-026 Rounding carry-out SHALL renormalise (fraction 0, exponent +1) and SHALL be checked for overflow after.
REQ-027 Biased result exp >= all-ones: out = {sign, all-ones exp, 0 frac}, error 01.
REQ-028 Biased result exp <= 0 with both inputs finite non-zero: out = {sign, 0, 0}, error 10.
REQ-029 Either input NaN, or Inf times zero: out = canonical qNaN {0, all-ones, 1 followed by zeros}, error 11.
REQ-030 Inf times finite non-zero, or Inf times Inf: out = signed Inf, error 00.
REQ-031 Zero times finite: out = signed zero, error 00.
REQ-032 Priority: invalid > Inf > zero > overflow > underflow > normal.

Reset
REQ-033 While rst is high, all stage valid bits, out_valid, out and error SHALL be 0, asynchronously.
REQ-034 in_ready SHALL read 1 during and after reset.
REQ-035 Reset mid-operation SHALL discard all in-flight results; first post-reset result appears STAGES cycles after the next transfer.

Structure
REQ-036 A shared package fp_pkg SHALL hold the bias function, error-code constants (ERR_NONE, ERR_OVF, ERR_UNF, ERR_INV), and canonical-NaN/Inf builders.
REQ-037 Normalise-and-round logic SHALL be one combinational sub-module fp_mul_round; fp_mul_pipe owns classification, pipeline registers, and handshake.
REQ-038 Stage split: stage 1 classify + exponent sum; mantissa product and round distributed over remaining stages; STAGES=1 places everything before one register.

Verification (defaults, out_ready=1 unless stated)
REQ-039 0x4000 * 0x4040 -> 0x40C0, error 00, out_valid exactly 3 cycles after transfer.
REQ-040 0x3FC0 * 0x3F81, rnd_mode=0 -> 0x3FC2; rnd_mode=1 -> 0x3FC1; 0x3F81*0x3F81 -> 0x3F82.
REQ-041 0x7F00 * 0x7F00 -> 0x7F80 err 01; 0x0080 * 0x0080 -> 0x0000 err 10; 0xFF00 * 0x7F00 -> 0xFF80 err 01.
REQ-042 0x7F80 * 0x0000 -> 0x7FC0 err 11; 0x7F80 * 0xBF80 -> 0xFF80 err 00; 0x0001 * 0x4000 -> 0x0000 err 00.
REQ-043 Stream 8 back-to-back pairs, drop out_ready for 5 cycles mid-stream -> in_ready low within same cycle, out stable, all 8 results in order, none lost.
REQ-044 Assert rst with 3 results in flight -> out_valid 0 immediately, no stale result after release.
